// File: rtl/cube0414_pkg.sv
// Shared definitions for the cube LED driver: scan-sequencer states, LED
// addressing, default timing constants and the SPI command bytes.
package cube0414_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_RD,
        ST_SEND,
        ST_LATCH
    } scan_state_e;

    localparam int unsigned LED_ADDR_WIDTH     = 6;
    localparam int unsigned LATCH_CYCLES_DEF   = 4000;
    localparam int unsigned REFRESH_CYCLES_DEF = 1600000;

    // Command bytes understood by the SPI-side layer writer
    localparam logic [7:0] CMD_SEL_LAYER = 8'h2a;
    localparam logic [7:0] CMD_WR_DATA   = 8'h2b;
    localparam logic [7:0] CMD_COMMIT    = 8'h2c;

endpackage

// File: rtl/layer_scan_ctl_scan_timer.sv
// scan_timer: loadable down-counter; expired_out is high while the count is zero.
module scan_timer #(
    parameter int unsigned      WIDTH   = 12,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    input  logic             en_in,
    output logic             expired_out
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_val_in;
        end else if (en_in && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_out = (count_q == '0);

endmodule

// File: rtl/layer_scan_ctl.sv
// layer_scan_ctl: walks the layer RAMs, kicks the WS2812 encoders per LED and
// holds the latch gap. Define LAYER_SCAN_AUTO_REFRESH_EN for idle auto re-scan.
module layer_scan_ctl
    import cube0414_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = LED_ADDR_WIDTH,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned RST_CYCLES     = LATCH_CYCLES_DEF,
    parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_rdy_in,
    input  logic                  bit_done_in,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic                  bit_start_out,
    output logic                  latch_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int unsigned LATCH_W   = $clog2(RST_CYCLES + 1);
    localparam int unsigned WAIT_LOAD = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("layer_scan_ctl: RD_LAT must be 1..3");
    end
    if (RST_CYCLES < 2) begin : g_bad_rst_cycles
        $error("layer_scan_ctl: RST_CYCLES must be at least 2");
    end
    if (REFRESH_CYCLES == 0) begin : g_bad_refresh_cycles
        $error("layer_scan_ctl: REFRESH_CYCLES must be non-zero");
    end

    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            wait_q, wait_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  start_q, start_d;
    logic                  latch_load;
    logic                  latch_expired;
    logic                  refresh_fire;
    logic                  scan_req;

    scan_timer #(
        .WIDTH   (LATCH_W),
        .RST_VAL ('0)
    ) u_latch_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (latch_load),
        .load_val_in (LATCH_W'(RST_CYCLES - 1)),
        .en_in       (state_q == ST_LATCH),
        .expired_out (latch_expired)
    );

`ifdef LAYER_SCAN_AUTO_REFRESH_EN
    localparam int unsigned REFRESH_W = $clog2(REFRESH_CYCLES + 1);

    logic refresh_expired;

    // Preset out of reset so the idle interval is measured from reset release too
    scan_timer #(
        .WIDTH   (REFRESH_W),
        .RST_VAL (REFRESH_W'(REFRESH_CYCLES - 1))
    ) u_refresh_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     ((state_q != ST_IDLE) || frame_rdy_in),
        .load_val_in (REFRESH_W'(REFRESH_CYCLES - 1)),
        .en_in       (state_q == ST_IDLE),
        .expired_out (refresh_expired)
    );

    assign refresh_fire = (state_q == ST_IDLE) && refresh_expired;
`else
    assign refresh_fire = 1'b0;
`endif

    assign scan_req = frame_rdy_in || refresh_fire;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        pending_d  = pending_q;
        latch_load = 1'b0;

        if ((state_q != ST_IDLE) && frame_rdy_in) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (scan_req) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (RD_LAT == 1) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_WAIT_RD;
                    wait_d  = 2'(WAIT_LOAD);
                end
            end
            ST_WAIT_RD: begin
                if (wait_q == 2'd0) begin
                    state_d = ST_SEND;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_SEND: begin
                if (bit_done_in) begin
                    if (addr_q == '1) begin
                        state_d    = ST_LATCH;
                        latch_load = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_LATCH: begin
                // A request landing on the last gap cycle chains straight into the next scan
                if (latch_expired) begin
                    if (pending_q || frame_rdy_in) begin
                        state_d   = ST_READ;
                        addr_d    = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        start_d = (state_d == ST_SEND) && (state_q != ST_SEND);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wait_q    <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
        end
    end

    assign rd_en_out      = (state_q == ST_READ);
    assign rd_addr_out    = addr_q;
    assign bit_start_out  = start_q;
    assign latch_out      = (state_q == ST_LATCH);
    assign busy_out       = busy_q;
    assign frame_done_out = (state_q == ST_LATCH) && latch_expired;

endmodule

// File: tb/tb_layer_scan_ctl.sv
// Scoreboard bench for layer_scan_ctl: two instances (RD_LAT 1 and 3) driven in
// turn by a reactive encoder model; an event-level reference predicts every output.
`timescale 1ns/1ps
module tb_layer_scan_ctl;

    localparam int AW   = 6;
    localparam int NLED = 64;
    localparam int RSTC = 20;
    localparam int REFC = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_rdy  [2];
    logic          bit_done   [2];
    logic          rd_en      [2];
    logic [AW-1:0] rd_addr    [2];
    logic          bit_start  [2];
    logic          latch      [2];
    logic          busy       [2];
    logic          frame_done [2];

    layer_scan_ctl #(
        .ADDR_WIDTH     (AW),
        .RD_LAT         (1),
        .RST_CYCLES     (RSTC),
        .REFRESH_CYCLES (REFC)
    ) u_dut_lat1 (
        .clk_in         (clk),
        .rst_in         (rst),
        .frame_rdy_in   (frame_rdy[0]),
        .bit_done_in    (bit_done[0]),
        .rd_en_out      (rd_en[0]),
        .rd_addr_out    (rd_addr[0]),
        .bit_start_out  (bit_start[0]),
        .latch_out      (latch[0]),
        .busy_out       (busy[0]),
        .frame_done_out (frame_done[0])
    );

    layer_scan_ctl #(
        .ADDR_WIDTH     (AW),
        .RD_LAT         (3),
        .RST_CYCLES     (RSTC),
        .REFRESH_CYCLES (REFC)
    ) u_dut_lat3 (
        .clk_in         (clk),
        .rst_in         (rst),
        .frame_rdy_in   (frame_rdy[1]),
        .bit_done_in    (bit_done[1]),
        .rd_en_out      (rd_en[1]),
        .rd_addr_out    (rd_addr[1]),
        .bit_start_out  (bit_start[1]),
        .latch_out      (latch[1]),
        .busy_out       (busy[1]),
        .frame_done_out (frame_done[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int sel    = 0;
    int lat    = 1;

    typedef struct {
        int cyc;
        int addr;
    } rd_ev_t;

    // Expected events, keyed by the cycle they must appear in
    rd_ev_t rd_q[$];
    int     st_q[$];
    int     dn_q[$];
    int     idle_q[$];

    // Reference model of the scan
    bit active;
    bit pending;
    int cur_addr;
    int latch_end;
    int idle_since;

    // Encoder responder and scripted requests
    int done_at;
    int rd_seen;
    bit start_now;
    int dmode;
    bit fr_now;
    bit req_mid;
    int mid_fired;
    bit req_last;
    bit last_fired;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, RD_LAT %0d)", name, act, exp, cyc, lat);
        end
    endtask

    function automatic int outs(input int s);
        return int'({rd_en[s], bit_start[s], latch[s], busy[s], frame_done[s], rd_addr[s]});
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents (or should present) an event
    always @(negedge clk) begin
        bit exp_rd;
        bit exp_st;
        bit exp_dn;
        bit exp_l;
        if (rst) begin
            chk("reset_outputs", outs(sel), 0);
        end else begin
            exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            exp_st = (st_q.size() > 0) && (st_q[0] == cyc);
            exp_dn = (dn_q.size() > 0) && (dn_q[0] == cyc);
            exp_l  = (dn_q.size() > 0) && (cyc > dn_q[0] - RSTC) && (cyc <= dn_q[0]);
            if (rd_en[sel] || exp_rd) begin
                chk("rd_en", int'(rd_en[sel]), int'(exp_rd));
                if (exp_rd) begin
                    if (rd_en[sel]) chk("rd_addr", int'(rd_addr[sel]), rd_q[0].addr);
                    chk("busy_on_read", int'(busy[sel]), 1);
                    void'(rd_q.pop_front());
                end
            end
            if (bit_start[sel] || exp_st) begin
                chk("bit_start", int'(bit_start[sel]), int'(exp_st));
                if (exp_st) void'(st_q.pop_front());
            end
            if (latch[sel] || exp_l) begin
                chk("latch", int'(latch[sel]), int'(exp_l));
            end
            if (frame_done[sel] || exp_dn) begin
                chk("frame_done", int'(frame_done[sel]), int'(exp_dn));
                if (exp_dn) begin
                    chk("busy_on_done", int'(busy[sel]), 1);
                    void'(dn_q.pop_front());
                end
            end
            if ((idle_q.size() > 0) && (idle_q[0] == cyc)) begin
                chk("busy_after_frame", int'(busy[sel]), 0);
                void'(idle_q.pop_front());
            end
        end
    end

    task automatic start_scan();
        active   = 1'b1;
        cur_addr = 0;
        rd_q.push_back('{cyc + 1, 0});
        st_q.push_back(cyc + 1 + lat);
    endtask

    // One clock cycle: react to DUT strobes, drive inputs, advance the reference
    task automatic step();
        bit fr;
        bit gen;
        bit spur;
        @(negedge clk);
        #1;
        start_now = 1'b0;
        if (rd_en[sel]) rd_seen = cyc;
        if (bit_start[sel]) begin
            start_now = 1'b1;
            done_at   = cyc + ((dmode == 0) ? 30 : int'($urandom_range(0, 5)));
        end
        fr = fr_now;
        if (req_mid && (mid_fired < 2) && start_now && (cur_addr == ((mid_fired == 0) ? 20 : 40))) begin
            fr = 1'b1;
            mid_fired++;
        end
        if (req_last && !last_fired && active && (cyc == latch_end)) begin
            fr = 1'b1;
            last_fired = 1'b1;
        end
        gen  = (cyc == done_at);
        spur = !gen && ($urandom_range(0, 3) == 0) &&
               (!active || ((latch_end >= 0) && (cyc > latch_end - RSTC)) || (cyc < rd_seen + lat));
        frame_rdy[sel] = fr;
        bit_done[sel]  = gen || spur;

        if (fr) begin
            if (!active) start_scan();
            else pending = 1'b1;
        end
`ifdef LAYER_SCAN_AUTO_REFRESH_EN
        else if (!active && (cyc == idle_since + REFC - 1)) begin
            start_scan();
        end
`endif
        if (gen) begin
            done_at = -1;
            if (cur_addr < NLED - 1) begin
                cur_addr++;
                rd_q.push_back('{cyc + 1, cur_addr});
                st_q.push_back(cyc + 1 + lat);
            end else begin
                latch_end = cyc + RSTC;
                dn_q.push_back(latch_end);
            end
        end else if (active && (cyc == latch_end)) begin
            latch_end = -1;
            if (pending) begin
                pending = 1'b0;
                start_scan();
            end else begin
                active     = 1'b0;
                idle_since = cyc + 1;
                idle_q.push_back(cyc + 1);
            end
        end
    endtask

    // Asserts reset in the current cycle, holds it three cycles, then releases
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            frame_rdy[i] = 1'b0;
            bit_done[i]  = 1'b0;
        end
        #1;
        chk("reset_async_outputs", outs(sel), 0);
        rd_q.delete();
        st_q.delete();
        dn_q.delete();
        idle_q.delete();
        active    = 1'b0;
        pending   = 1'b0;
        cur_addr  = 0;
        latch_end = -1;
        done_at   = -1;
        rd_seen   = -100;
        repeat (3) @(negedge clk);
        #1;
        rst        = 1'b0;
        idle_since = cyc;
    endtask

    task automatic request();
        fr_now = 1'b1;
        step();
        fr_now = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((active || (rd_q.size() > 0) || (st_q.size() > 0) || (dn_q.size() > 0) ||
                (idle_q.size() > 0)) && (n < limit)) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, int'(n >= limit), 0);
    endtask

    task automatic run_instance(input int s);
        int n;
        sel = s;
        lat = (s == 0) ? 1 : 3;
        do_reset();
        repeat (3) step();
        chk("idle_busy", int'(busy[sel]), 0);
        chk("idle_rd_addr", int'(rd_addr[sel]), 0);

        dmode = 0;
        request();
        wait_idle(4000, "frame_single");

        dmode     = 1;
        req_mid   = 1'b1;
        mid_fired = 0;
        repeat (2) step();
        request();
        wait_idle(3000, "frame_mid_requests");
        req_mid = 1'b0;

        req_last   = 1'b1;
        last_fired = 1'b0;
        repeat (2) step();
        request();
        wait_idle(3000, "frame_last_cycle_request");
        req_last = 1'b0;

        repeat (2) step();
        request();
        n = 0;
        while (!(start_now && (cur_addr == 33)) && (n < 3000)) begin
            step();
            n++;
        end
        chk("reach_addr33_timeout", int'(n >= 3000), 0);
        do_reset();
        repeat (150) step();
`ifndef LAYER_SCAN_AUTO_REFRESH_EN
        chk("idle_after_reset", int'(busy[sel]), 0);
`endif
        request();
        wait_idle(3000, "frame_after_reset");

        repeat (300) step();
`ifndef LAYER_SCAN_AUTO_REFRESH_EN
        chk("long_idle_busy", int'(busy[sel]), 0);
`endif
        wait_idle(3000, "final_drain");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            frame_rdy[i] = 1'b0;
            bit_done[i]  = 1'b0;
        end
        active     = 1'b0;
        pending    = 1'b0;
        cur_addr   = 0;
        latch_end  = -1;
        idle_since = 0;
        done_at    = -1;
        rd_seen    = -100;
        start_now  = 1'b0;
        dmode      = 0;
        fr_now     = 1'b0;
        req_mid    = 1'b0;
        mid_fired  = 0;
        req_last   = 1'b0;
        last_fired = 1'b0;
        @(negedge clk);
        #1;
        run_instance(0);
        run_instance(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
